// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants and shared decode helper
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_PIX_DIV   = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_HSYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_VSYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC - 1;

  function automatic logic in_range(input logic [COORD_W-1:0] v,
                                    input logic [COORD_W-1:0] lo,
                                    input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - divide-by-PIX_DIV strobe generator (1..16), one-cycle tick
module pixel_tick_gen #(
  parameter int PIX_DIV = 4
) (
  input  logic boardCLK,
  input  logic reset,
  output logic tick
);

  logic [3:0] div_cnt_q, div_cnt_d;

  assign tick = (div_cnt_q == 4'(PIX_DIV - 1));

  always_comb begin
    div_cnt_d = tick ? 4'd0 : div_cnt_q + 4'd1;
  end

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) div_cnt_q <= 4'd0;
    else        div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters and sync/blank decode on a pixel strobe
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int PIX_DIV     = DEF_PIX_DIV,
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic               boardCLK,
  input  logic               reset,
  output logic               pixelTick,
  output logic               hsync,
  output logic               vsync,
  output logic               videoOn,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frameStart,
  output logic               lineEnd
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ON  = 1'(SYNC_ACTIVE);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic tick;

  pixel_tick_gen #(.PIX_DIV(PIX_DIV)) u_pixel_tick_gen (
    .boardCLK (boardCLK),
    .reset    (reset),
    .tick     (tick)
  );

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic pixel_tick_q, pixel_tick_d, frame_start_q, frame_start_d, line_end_q, line_end_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
    // Decode from the next-state counters so x/y and every flag describe the same pixel.
    hsync_d       = in_range(x_d, HS_START, HS_END) ? SYNC_ON : SYNC_OFF;
    vsync_d       = in_range(y_d, VS_START, VS_END) ? SYNC_ON : SYNC_OFF;
    video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
    pixel_tick_d  = tick;
    frame_start_d = tick && (x_d == '0) && (y_d == '0);
    line_end_d    = tick && (x_d == H_LAST);
  end

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      video_on_q    <= 1'b0;
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_tick_q  <= pixel_tick_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign videoOn    = video_on_q;
  assign pixelTick  = pixel_tick_q;
  assign frameStart = frame_start_q;
  assign lineEnd    = line_end_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed bench: default timing, PIX_DIV=1 active-high, reduced raster
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r4 = 1'b0, r1 = 1'b0, rs = 1'b0;

  logic pt4, hs4, vs4, vo4, fs4, le4;
  logic pt1, hs1, vs1, vo1, fs1, le1;
  logic pts, hss, vss, vos, fss, les;
  logic [9:0] x4, y4, x1, y1, xs, ys;

  vga_sync_gen dut (
    .boardCLK(clk), .reset(r4), .pixelTick(pt4), .hsync(hs4), .vsync(vs4),
    .videoOn(vo4), .x(x4), .y(y4), .frameStart(fs4), .lineEnd(le4)
  );

  vga_sync_gen #(.PIX_DIV(1), .SYNC_ACTIVE(1)) dut_p1 (
    .boardCLK(clk), .reset(r1), .pixelTick(pt1), .hsync(hs1), .vsync(vs1),
    .videoOn(vo1), .x(x1), .y(y1), .frameStart(fs1), .lineEnd(le1)
  );

  // 24x13 raster: hsync x in [18,20], vsync y in [9,10]
  vga_sync_gen #(.PIX_DIV(2), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                 .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) dut_s (
    .boardCLK(clk), .reset(rs), .pixelTick(pts), .hsync(hss), .vsync(vss),
    .videoOn(vos), .x(xs), .y(ys), .frameStart(fss), .lineEnd(les)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n, cnt, von, vlow, hlow, lec, fsc;

  initial begin
    // ---------------- default timing, PIX_DIV=4 ----------------
    cyc(10);
    chk("rst_x", x4, 799);        chk("rst_y", y4, 524);
    chk("rst_hs", hs4, 1);        chk("rst_vs", vs4, 1);
    chk("rst_von", vo4, 0);       chk("rst_pt", pt4, 0);
    chk("rst_fs", fs4, 0);        chk("rst_le", le4, 0);
    r4 = 1'b1;
    cyc(3);
    chk("pre_tick_x", x4, 799);   chk("pre_tick_von", vo4, 0);
    chk("pre_tick_fs", fs4, 0);
    cyc(1);
    chk("first_x", x4, 0);        chk("first_y", y4, 0);
    chk("first_von", vo4, 1);     chk("first_fs", fs4, 1);
    chk("first_pt", pt4, 1);      chk("first_hs", hs4, 1);
    cyc(1);
    chk("fs_one_cycle", fs4, 0);  chk("pt_one_cycle", pt4, 0);
    chk("hold_x", x4, 0);
    n = 0;
    do begin cyc(1); n++; end while (hs4 !== 1'b0 && n < 5000);
    chk("hs_fall_delay", n, 2623);
    chk("hs_fall_x", x4, 656);
    n = 0;
    do begin cyc(1); n++; end while (hs4 !== 1'b1 && n < 5000);
    chk("hs_low_cycles", n, 384);
    chk("hs_rise_x", x4, 752);
    n = 0;
    do begin cyc(1); n++; end while (le4 !== 1'b1 && n < 5000);
    chk("le_delay", n, 188);
    chk("le_x", x4, 799);         chk("le_y", y4, 0);
    n = 0;
    do begin cyc(1); n++; end while (le4 !== 1'b1 && n < 5000);
    chk("line_period", n, 3200);
    chk("le2_y", y4, 1);
    cyc(1204);
    chk("mid_x", x4, 300);        chk("mid_y", y4, 2);
    chk("mid_hs", hs4, 1);        chk("mid_von", vo4, 1);
    #1 r4 = 1'b0;
    #1;
    chk("async_x", x4, 799);      chk("async_y", y4, 524);
    chk("async_von", vo4, 0);     chk("async_hs", hs4, 1);
    chk("async_vs", vs4, 1);
    cyc(3);
    r4 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (hs4 === 1'b1 && vs4 === 1'b1) cnt++;
    end
    chk("rerelease_no_glitch", cnt, 4);
    chk("rerelease_x", x4, 0);    chk("rerelease_y", y4, 0);
    chk("rerelease_fs", fs4, 1);

    // ---------------- PIX_DIV=1, active-high sync ----------------
    chk("p1_rst_hs", hs1, 0);     chk("p1_rst_vs", vs1, 0);
    chk("p1_rst_x", x1, 799);     chk("p1_rst_von", vo1, 0);
    r1 = 1'b1;
    cyc(1);
    chk("p1_first_x", x1, 0);     chk("p1_first_y", y1, 0);
    chk("p1_first_fs", fs1, 1);   chk("p1_first_pt", pt1, 1);
    chk("p1_idle_hs", hs1, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (pt1 === 1'b1) cnt++;
    end
    chk("p1_pt_every_cycle", cnt, 8);
    chk("p1_x_after8", x1, 8);
    n = 0;
    do begin cyc(1); n++; end while (hs1 !== 1'b1 && n < 2000);
    chk("p1_hs_rise_delay", n, 648);
    chk("p1_hs_rise_x", x1, 656);
    n = 0;
    do begin cyc(1); n++; end while (le1 !== 1'b1 && n < 2000);
    chk("p1_le_delay", n, 143);
    n = 0;
    do begin cyc(1); n++; end while (le1 !== 1'b1 && n < 2000);
    chk("p1_line_period", n, 800);
    chk("p1_vs_idle", vs1, 0);

    // ---------------- reduced raster, PIX_DIV=2 ----------------
    rs = 1'b1;
    cyc(2);
    chk("s_first_fs", fss, 1);    chk("s_first_x", xs, 0);
    von = 0; vlow = 0; hlow = 0; lec = 0; fsc = 0;
    for (int i = 0; i < 624; i++) begin
      cyc(1);
      if (pts) begin
        if (vos)  von++;
        if (!vss) vlow++;
        if (!hss) hlow++;
      end
      if (les) lec++;
      if (fss) fsc++;
    end
    chk("s_video_ticks", von, 128);
    chk("s_vsync_ticks", vlow, 48);
    chk("s_hsync_ticks", hlow, 39);
    chk("s_lineend_count", lec, 13);
    chk("s_framestart_count", fsc, 1);
    chk("s_frame_wrap_fs", fss, 1);
    chk("s_frame_wrap_xy", {xs, ys}, 0);
    cyc(30);
    chk("s_last_vis_x", xs, 15);  chk("s_last_vis_von", vos, 1);
    cyc(2);
    chk("s_first_blank_x", xs, 16); chk("s_first_blank_von", vos, 0);
    cyc(304);
    chk("s_last_vis_line", ys, 7); chk("s_last_line_von", vos, 1);
    cyc(48);
    chk("s_first_blank_line", ys, 8); chk("s_blank_line_von", vos, 0);
    chk("s_pre_vsync", vss, 1);
    cyc(48);
    chk("s_vsync_line9", vss, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
